// File: rtl/bit_serial_alu.sv
// Bit-serial ALU stage feeding an LSB-first accumulator shift register.
// Drives the accumulator/operand strobes for WIDTH cycles and reports carry/zero flags.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [2:0] i_op,
  input  logic       i_acc_bit,
  input  logic       i_opnd_bit,
  output logic       o_result_bit,
  output logic       o_con_shift,
  output logic       o_con_write,
  output logic       o_opnd_shift,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_carry,
  output logic       o_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpLoad = 3'b101,
    OpClr  = 3'b110,
    OpPass = 3'b111
  } op_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic            carry_flag_q, carry_flag_d;
  logic            zero_flag_q, zero_flag_d;

  logic b_eff, cout, res, arith;

  // SUB is a + ~b + 1, with the +1 preloaded into carry_q at start.
  assign b_eff = (op_q == OpSub) ? ~i_opnd_bit : i_opnd_bit;
  assign cout  = (i_acc_bit & b_eff) | (i_acc_bit & carry_q) | (b_eff & carry_q);
  assign arith = (op_q == OpAdd) || (op_q == OpSub);

  always_comb begin
    res = 1'b0;
    unique case (op_q)
      OpAdd, OpSub: res = i_acc_bit ^ b_eff ^ carry_q;
      OpAnd:        res = i_acc_bit & i_opnd_bit;
      OpOr:         res = i_acc_bit | i_opnd_bit;
      OpXor:        res = i_acc_bit ^ i_opnd_bit;
      OpLoad:       res = i_opnd_bit;
      OpClr:        res = 1'b0;
      OpPass:       res = i_acc_bit;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    zacc_d       = zacc_q;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
    o_result_bit = 1'b0;
    o_con_shift  = 1'b0;
    o_con_write  = 1'b0;
    o_opnd_shift = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          op_d    = op_e'(i_op);
          cnt_d   = '0;
          carry_d = (i_op == OpSub);
          zacc_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        o_busy       = 1'b1;
        o_con_shift  = 1'b1;
        o_opnd_shift = 1'b1;
        o_con_write  = (op_q != OpClr);
        o_result_bit = res;
        if (arith) carry_d = cout;
        zacc_d = zacc_q & ~res;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d      = StDone;
          carry_flag_d = arith & cout;
          zero_flag_d  = zacc_q & ~res;
        end
      end
      StDone: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      op_q         <= OpAdd;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      zacc_q       <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      zacc_q       <= zacc_d;
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
    end
  end

  assign o_carry = carry_flag_q;
  assign o_zero  = zero_flag_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Bench for bit_serial_alu: models the accumulator and operand shift registers around the DUT
// and checks results, flags, strobe counts and timing against hand-computed vectors.
module tb_bit_serial_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic       res_bit, con_shift, con_write, opnd_shift, busy, done, carry, zero;

  logic [7:0] acc = 8'h00;
  logic [7:0] opnd = 8'h00;
  logic       ld = 1'b0;
  logic [7:0] ld_a = 8'h00;
  logic [7:0] ld_b = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_serial_alu #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_op         (op),
    .i_acc_bit    (acc[0]),
    .i_opnd_bit   (opnd[0]),
    .o_result_bit (res_bit),
    .o_con_shift  (con_shift),
    .o_con_write  (con_write),
    .o_opnd_shift (opnd_shift),
    .o_busy       (busy),
    .o_done       (done),
    .o_carry      (carry),
    .o_zero       (zero)
  );

  // Accumulator and operand shift registers surrounding the ALU.
  always @(posedge clk) begin
    if (ld) begin
      acc  <= ld_a;
      opnd <= ld_b;
    end else begin
      if (con_shift) acc <= {con_write ? res_bit : 1'b0, acc[7:1]};
      if (opnd_shift) opnd <= {1'b0, opnd[7:1]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t vecs[10];

  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input logic ec,
                        input logic ez);
    int shifts = 0;
    int writes = 0;
    int dones = 0;
    int done_cyc = 0;
    logic c_at_done = 1'bx;
    logic z_at_done = 1'bx;
    @(negedge clk);
    ld = 1'b1; ld_a = a; ld_b = b;
    @(negedge clk);
    ld = 1'b0;
    start = 1'b1; op = o;
    @(negedge clk);
    start = 1'b0; op = ~o;  // later opcode changes must not matter
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (con_shift) shifts++;
      if (con_shift && con_write) writes++;
      if (done) begin
        dones++;
        if (done_cyc == 0) begin
          done_cyc  = k;
          c_at_done = carry;
          z_at_done = zero;
        end
      end
    end
    check({tag, " acc"}, 32'(acc), 32'(exp));
    check({tag, " carry"}, 32'(c_at_done), 32'(ec));
    check({tag, " zero"}, 32'(z_at_done), 32'(ez));
    check({tag, " shifts"}, shifts, 8);
    check({tag, " writes"}, writes, (o == 3'b110) ? 0 : 8);
    check({tag, " done_cycle"}, done_cyc, 9);
    check({tag, " done_count"}, dones, 1);
  endtask

  initial begin
    vecs[0] = '{3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0};  // ADD
    vecs[1] = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};  // ADD wrap
    vecs[2] = '{3'b001, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b1};  // SUB equal
    vecs[3] = '{3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};  // AND clears old carry
    vecs[4] = '{3'b001, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};  // SUB borrow
    vecs[5] = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};  // OR
    vecs[6] = '{3'b100, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};  // XOR
    vecs[7] = '{3'b101, 8'h33, 8'hA5, 8'hA5, 1'b0, 1'b0};  // LOAD
    vecs[8] = '{3'b110, 8'h5A, 8'hFF, 8'h00, 1'b0, 1'b1};  // CLR
    vecs[9] = '{3'b111, 8'h77, 8'hC3, 8'h77, 1'b0, 1'b0};  // PASS

    #1;
    check("reset_outputs",
          32'({res_bit, con_shift, con_write, opnd_shift, busy, done, carry, zero}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].ec, vecs[i].ez);
    end

    // start held high: accepted only from IDLE, period WIDTH+2
    begin
      int shifts = 0;
      int dones = 0;
      int first_done = 0;
      int last_done = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b000;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (con_shift) shifts++;
        if (done) begin
          dones++;
          if (first_done == 0) first_done = k;
          last_done = k;
        end
        if (k == 30) start = 1'b0;
      end
      check("held_start shifts", shifts, 24);
      check("held_start dones", dones, 3);
      check("held_start first_done", first_done, 9);
      check("held_start last_done", last_done, 29);
    end

    // CLR sets o_zero so the reset test can see it cleared
    run_op("pre_reset_clr", 3'b110, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1);

    begin
      int dones = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b000;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_run busy", 32'(busy), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset outputs",
            32'({res_bit, con_shift, con_write, opnd_shift, busy, done, carry, zero}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done || busy || con_shift) dones++;
      end
      check("post_reset idle", dones, 0);
    end

    run_op("post_reset_add", 3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
